// File: rtl/sprite_draw_datapath.sv
// ============================================================================
// sprite_draw_datapath: 4x4 sprite clear/draw, movement and shot logic.
// Optional hit counter: define SPRITE_HIT_COUNT_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_draw_datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] STATE,
  input  logic       PorB,
  input  logic       fly,
  input  logic       fall,
  input  logic       shoot,
  output logic       doneDrawing,
  output logic       isShot,
  output logic       escape,
  output logic       leave,
  output logic       outOfAmmo,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic [7:0] hits
);

  localparam logic [3:0] c_ST_HOLD    = 4'b0000;
  localparam logic [3:0] c_ST_CLEAR   = 4'b0001;
  localparam logic [3:0] c_ST_RIGHT   = 4'b0010;
  localparam logic [3:0] c_ST_LEFT    = 4'b0011;
  localparam logic [3:0] c_ST_DRAW    = 4'b0101;
  localparam logic [3:0] c_ST_DOWN    = 4'b0110;
  localparam logic [3:0] c_ST_UP      = 4'b0111;
  localparam logic [3:0] c_ST_IS_SHOT = 4'b1010;
  localparam logic [7:0] c_X_MAX      = 8'd156;
  localparam logic [6:0] c_Y_MAX      = 7'd116;

  logic [7:0] r_px, r_bx;
  logic [6:0] r_py, r_by;
  logic [1:0] r_ammo;
  logic [3:0] r_prev_state, r_pass_state;
  logic       r_active;
  logic [4:0] r_cnt;

  logic       w_is_pass, w_start, w_respawn, w_fire, w_hit, w_inside;
  logic [7:0] w_cx, w_x_sel, w_x_inc, w_x_dec, w_base_x, w_pix_x;
  logic [6:0] w_cy, w_y_sel, w_y_inc, w_y_dec, w_base_y, w_pix_y;
  logic [3:0] w_pix;
  logic [2:0] w_colour;
  logic [1:0] w_ammo_nxt;

  assign w_is_pass = (STATE == c_ST_CLEAR) || (STATE == c_ST_DRAW);
  assign w_start   = w_is_pass && (STATE != r_prev_state);
  assign w_respawn = (STATE == c_ST_IS_SHOT) && leave;

  // Hit test: player crosshair centre against the bird's 4x4 box.
  assign w_cx      = r_px + 8'd2;
  assign w_cy      = r_py + 7'd2;
  assign w_inside  = (w_cx >= r_bx) && (w_cx <= r_bx + 8'd3) &&
                     (w_cy >= r_by) && (w_cy <= r_by + 7'd3);
  assign w_fire    = shoot && (r_ammo != 2'd0);
  assign w_hit     = w_fire && w_inside;
  assign w_ammo_nxt = w_respawn ? 2'd3 : (w_fire ? r_ammo - 2'd1 : r_ammo);

  assign w_x_sel = PorB ? r_bx : r_px;
  assign w_y_sel = PorB ? r_by : r_py;
  assign w_x_inc = (w_x_sel < c_X_MAX) ? w_x_sel + 8'd1 : w_x_sel;
  assign w_x_dec = (w_x_sel != 8'd0)   ? w_x_sel - 8'd1 : w_x_sel;
  assign w_y_inc = (w_y_sel < c_Y_MAX) ? w_y_sel + 7'd1 : w_y_sel;
  assign w_y_dec = (w_y_sel != 7'd0)   ? w_y_sel - 7'd1 : w_y_sel;

  assign w_pix    = w_start ? 4'd0 : r_cnt[3:0];
  assign w_base_x = PorB ? r_bx : r_px;
  assign w_base_y = PorB ? r_by : r_py;
  assign w_pix_x  = w_base_x + {6'd0, w_pix[1:0]};
  assign w_pix_y  = w_base_y + {5'd0, w_pix[3:2]};
  assign w_colour = (STATE == c_ST_CLEAR) ? 3'b011 :
                    (!PorB)               ? 3'b111 :
                    (fall)                ? 3'b110 : 3'b100;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_px <= 8'd78;
      r_py <= 7'd58;
      r_bx <= 8'd78;
      r_by <= 7'd100;
    end else if (w_respawn) begin
      r_bx <= 8'd78;
      r_by <= 7'd100;
    end else begin
      case (STATE)
        c_ST_RIGHT: if (PorB) r_bx <= w_x_inc; else r_px <= w_x_inc;
        c_ST_LEFT:  if (PorB) r_bx <= w_x_dec; else r_px <= w_x_dec;
        c_ST_DOWN:  if (PorB) r_by <= w_y_inc; else r_py <= w_y_inc;
        c_ST_UP:    if (PorB) r_by <= w_y_dec; else r_py <= w_y_dec;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ammo    <= 2'd3;
      isShot    <= 1'b0;
      escape    <= 1'b0;
      leave     <= 1'b0;
      outOfAmmo <= 1'b0;
    end else if (w_respawn) begin
      r_ammo    <= 2'd3;
      isShot    <= 1'b0;
      escape    <= 1'b0;
      leave     <= 1'b0;
      outOfAmmo <= 1'b0;
    end else begin
      r_ammo    <= w_ammo_nxt;
      outOfAmmo <= (w_ammo_nxt == 2'd0);
      if (w_hit) isShot <= 1'b1;
      // A hit on the final round suppresses the escape.
      if (w_fire && (r_ammo == 2'd1) && !isShot && !w_hit) escape <= 1'b1;
      if ((fall && (r_by == c_Y_MAX)) || (fly && (r_by == 7'd0))) leave <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_state <= c_ST_HOLD;
      r_pass_state <= c_ST_HOLD;
      r_active     <= 1'b0;
      r_cnt        <= 5'd0;
      doneDrawing  <= 1'b0;
      plot         <= 1'b0;
      x_out        <= 8'd0;
      y_out        <= 7'd0;
      colour       <= 3'd0;
    end else begin
      r_prev_state <= STATE;
      if (w_start) begin
        r_active     <= 1'b1;
        r_pass_state <= STATE;
        r_cnt        <= 5'd1;
        doneDrawing  <= 1'b0;
        plot         <= 1'b1;
        x_out        <= w_pix_x;
        y_out        <= w_pix_y;
        colour       <= w_colour;
      end else if (r_active) begin
        if (STATE == r_pass_state) begin
          if (r_cnt == 5'd16) begin
            r_active    <= 1'b0;
            plot        <= 1'b0;
            doneDrawing <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 5'd1;
            plot   <= 1'b1;
            x_out  <= w_pix_x;
            y_out  <= w_pix_y;
            colour <= w_colour;
          end
        end else begin
          r_active <= 1'b0;
          plot     <= 1'b0;
        end
      end else begin
        plot <= 1'b0;
        if (STATE != r_pass_state) doneDrawing <= 1'b0;
      end
    end
  end

`ifdef SPRITE_HIT_COUNT_EN
  logic [7:0] r_hits;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_hits <= 8'd0;
    else if (!w_respawn && w_hit && !isShot) r_hits <= r_hits + 8'd1;
  end
  assign hits = r_hits;
`else
  assign hits = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sprite_draw_datapath.sv
// ============================================================================
// tb_sprite_draw_datapath: directed + random stimulus vs behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sprite_draw_datapath;

  localparam int S_PREHOLD = 4, S_HOLD = 0, S_CLEAR = 1, S_RIGHT = 2, S_LEFT = 3;
  localparam int S_DOWN = 6, S_UP = 7, S_DRAW = 5, S_ISSHOT = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] STATE = 4'd0;
  logic       PorB = 1'b0, fly = 1'b0, fall = 1'b0, shoot = 1'b0;
  logic       doneDrawing, isShot, escape, leave, outOfAmmo, plot;
  logic [7:0] x_out, hits;
  logic [6:0] y_out;
  logic [2:0] colour;

  sprite_draw_datapath dut (
    .clk(clk), .reset(reset), .STATE(STATE), .PorB(PorB), .fly(fly), .fall(fall),
    .shoot(shoot), .doneDrawing(doneDrawing), .isShot(isShot), .escape(escape),
    .leave(leave), .outOfAmmo(outOfAmmo), .x_out(x_out), .y_out(y_out),
    .colour(colour), .plot(plot), .hits(hits)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: game state as plain integers.
  int m_px, m_py, m_bx, m_by, m_ammo, m_hits;
  bit m_isShot, m_escape, m_leave, m_plot, m_done, m_active;
  int m_xo, m_yo, m_col, m_prev, m_code, m_k;

  task automatic model_reset();
    m_px = 78; m_py = 58; m_bx = 78; m_by = 100; m_ammo = 3; m_hits = 0;
    m_isShot = 0; m_escape = 0; m_leave = 0; m_plot = 0; m_done = 0; m_active = 0;
    m_xo = 0; m_yo = 0; m_col = 0; m_prev = -1; m_code = -1; m_k = 0;
  endtask

  task automatic model_emit(int st, bit pb, bit fa);
    m_xo   = (pb ? m_bx : m_px) + (m_k % 4);
    m_yo   = (pb ? m_by : m_py) + (m_k / 4);
    m_col  = (st == S_CLEAR) ? 3 : (!pb ? 7 : (fa ? 6 : 4));
    m_plot = 1;
    m_k++;
  endtask

  task automatic model_clock(int st, bit pb, bit fl, bit fa, bit sh);
    bit respawn, leave_cond, fire, hit, is_pc;
    int cx, cy;
    respawn    = (st == S_ISSHOT) && m_leave;
    leave_cond = (fa && m_by == 116) || (fl && m_by == 0);
    fire       = sh && (m_ammo > 0);
    cx = m_px + 2; cy = m_py + 2;
    hit = fire && cx >= m_bx && cx <= m_bx + 3 && cy >= m_by && cy <= m_by + 3;
    is_pc = (st == S_CLEAR) || (st == S_DRAW);

    if (is_pc && st != m_prev) begin
      m_active = 1; m_code = st; m_k = 0; m_done = 0;
      model_emit(st, pb, fa);
    end else if (m_active) begin
      if (st == m_code) begin
        if (m_k == 16) begin m_active = 0; m_plot = 0; m_done = 1; end
        else model_emit(st, pb, fa);
      end else begin
        m_active = 0; m_plot = 0;
      end
    end else begin
      m_plot = 0;
      if (m_done && st != m_code) m_done = 0;
    end
    m_prev = st;

    if (respawn) begin
      m_bx = 78; m_by = 100; m_ammo = 3; m_isShot = 0; m_escape = 0; m_leave = 0;
    end else begin
      case (st)
        S_RIGHT: if (pb) m_bx = (m_bx < 156) ? m_bx + 1 : 156; else m_px = (m_px < 156) ? m_px + 1 : 156;
        S_LEFT:  if (pb) m_bx = (m_bx > 0) ? m_bx - 1 : 0;     else m_px = (m_px > 0) ? m_px - 1 : 0;
        S_DOWN:  if (pb) m_by = (m_by < 116) ? m_by + 1 : 116; else m_py = (m_py < 116) ? m_py + 1 : 116;
        S_UP:    if (pb) m_by = (m_by > 0) ? m_by - 1 : 0;     else m_py = (m_py > 0) ? m_py - 1 : 0;
        default: ;
      endcase
      if (fire) begin
        m_ammo--;
`ifdef SPRITE_HIT_COUNT_EN
        if (hit && !m_isShot) m_hits = (m_hits + 1) % 256;
`endif
        if (hit) m_isShot = 1;
        if (m_ammo == 0 && !m_isShot) m_escape = 1;
      end
      if (leave_cond) m_leave = 1;
    end
  endtask

  task automatic compare_all();
    check("plot", 32'(plot), 32'(m_plot));
    if (m_plot) begin
      check("x_out", 32'(x_out), 32'(m_xo));
      check("y_out", 32'(y_out), 32'(m_yo));
      check("colour", 32'(colour), 32'(m_col));
    end
    check("doneDrawing", 32'(doneDrawing), 32'(m_done));
    check("isShot", 32'(isShot), 32'(m_isShot));
    check("escape", 32'(escape), 32'(m_escape));
    check("leave", 32'(leave), 32'(m_leave));
    check("outOfAmmo", 32'(outOfAmmo), 32'(m_ammo == 0));
    check("hits", 32'(hits), 32'(m_hits));
  endtask

  task automatic cycle(int st, bit pb, bit fl, bit fa, bit sh);
    STATE = 4'(st); PorB = pb; fly = fl; fall = fa; shoot = sh;
    @(posedge clk);
    model_clock(st, pb, fl, fa, sh);
    #1;
    compare_all();
  endtask

  task automatic do_reset(int st);
    STATE = 4'(st); shoot = 1'b0; fly = 1'b0; fall = 1'b0; PorB = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  int codes[9] = '{S_PREHOLD, S_HOLD, S_CLEAR, S_RIGHT, S_LEFT, S_DOWN, S_UP, S_DRAW, S_ISSHOT};

  initial begin
    int nplot, done_at, r_st;
    bit r_pb, r_fl, r_fa, done_seen;
    model_reset();
    @(posedge clk); #1;

    // Reset released while CLEAR: full clear pass of the player.
    do_reset(S_CLEAR);
    nplot = 0; done_at = 0;
    for (int i = 1; i <= 18; i++) begin
      cycle(S_CLEAR, 0, 0, 0, 0);
      if (plot) nplot++;
      if (doneDrawing && done_at == 0) done_at = i;
    end
    check("clear_plot_count", 32'(nplot), 32'd16);
    check("clear_done_cycle", 32'(done_at), 32'd17);
    cycle(S_HOLD, 0, 0, 0, 0);
    cycle(S_HOLD, 0, 0, 0, 0);
    check("done_drop", 32'(doneDrawing), 32'd0);

    // Right-edge saturation, then a single step left, observed by a draw.
    for (int i = 0; i < 80; i++) cycle(S_RIGHT, 0, 0, 0, 0);
    cycle(S_LEFT, 0, 0, 0, 0);
    cycle(S_DRAW, 0, 0, 0, 0);
    check("x_after_left", 32'(x_out), 32'd155);
    for (int i = 0; i < 18; i++) cycle(S_DRAW, 0, 0, 0, 0);

    // Draw aborted at cycle 5.
    cycle(S_HOLD, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(S_DRAW, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(S_RIGHT, 0, 0, 0, 0);
      if (i == 0) check("abort_plot_low", 32'(plot), 32'd0);
      if (doneDrawing) done_seen = 1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Player to (77,99) and a hit on the bird at (78,100).
    do_reset(S_HOLD);
    cycle(S_LEFT, 0, 0, 0, 0);
    for (int i = 0; i < 41; i++) cycle(S_DOWN, 0, 0, 0, 0);
    cycle(S_HOLD, 0, 0, 0, 1);
    check("hit_isShot", 32'(isShot), 32'd1);
    check("hit_escape", 32'(escape), 32'd0);
`ifdef SPRITE_HIT_COUNT_EN
    check("hit_hits", 32'(hits), 32'd1);
`else
    check("hit_hits", 32'(hits), 32'd0);
`endif

    // Three misses exhaust the ammo; the fourth shot is ignored.
    do_reset(S_HOLD);
    for (int i = 0; i < 3; i++) begin cycle(S_HOLD, 0, 0, 0, 1); cycle(S_HOLD, 0, 0, 0, 0); end
    check("miss_outOfAmmo", 32'(outOfAmmo), 32'd1);
    check("miss_escape", 32'(escape), 32'd1);
    cycle(S_HOLD, 0, 0, 0, 1);
    check("miss_isShot", 32'(isShot), 32'd0);

    // Falling bird reaches the floor, leaves, and respawns.
    do_reset(S_HOLD);
    for (int i = 0; i < 16; i++) cycle(S_DOWN, 1, 0, 1, 0);
    cycle(S_HOLD, 1, 0, 1, 0);
    check("fall_leave", 32'(leave), 32'd1);
    cycle(S_ISSHOT, 1, 0, 1, 0);
    check("respawn_leave", 32'(leave), 32'd0);
    cycle(S_DRAW, 1, 0, 0, 0);
    check("respawn_bx", 32'(x_out), 32'd78);
    check("respawn_by", 32'(y_out), 32'd100);
    for (int i = 0; i < 18; i++) cycle(S_DRAW, 1, 0, 0, 0);

    // Random phase.
    r_st = S_HOLD; r_pb = 0; r_fl = 0; r_fa = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset(codes[$urandom_range(0, 8)]);
      if ((r_st == S_CLEAR || r_st == S_DRAW) ? ($urandom_range(0, 99) < 5)
                                               : ($urandom_range(0, 9) < 3))
        r_st = codes[$urandom_range(0, 8)];
      if ($urandom_range(0, 19) == 0) r_pb = ~r_pb;
      if ($urandom_range(0, 29) == 0) r_fl = ~r_fl;
      if ($urandom_range(0, 29) == 0) r_fa = ~r_fa;
      cycle(r_st, r_pb, r_fl, r_fa, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_draw_datapath.md
SPRITE_DRAW_DATAPATH -- requirements
Module: sprite_draw_datapath

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port STATE, input, 4 bits: movement state code (PREHOLD 0100, HOLD 0000, CLEAR 0001, RIGHT 0010, LEFT 0011, DOWN 0110, UP 0111, DRAW 0101, IS_SHOT 1010).
REQ-004 SHALL have port PorB, input, 1 bit: selected object, 0 = player crosshair, 1 = bird.
REQ-005 SHALL have ports fly and fall, input, 1 bit each: bird flying-off and falling modes.
REQ-006 SHALL have port shoot, input, 1 bit: one-cycle synchronous trigger pulse.
REQ-007 SHALL have port doneDrawing, output, 1 bit: current clear or draw pass complete.
REQ-008 SHALL have ports isShot, escape, leave and outOfAmmo, output, 1 bit each: game events.
REQ-009 SHALL have ports x_out (8), y_out (7), colour (3) and plot (1), output: pixel write to the 160x120 frame buffer.
REQ-010 SHALL have port hits, output, 8 bits: birds downed count.

Function
REQ-011 SHALL hold player and bird positions: x 0..156, y 0..116; sprites are 4x4.
REQ-012 SHALL start a 16-pixel pass on the first cycle STATE is CLEAR or DRAW, or when STATE changes between those two codes.
REQ-013 SHALL use pixel counter c[3:0] during a pass: x_out = base_x + c[1:0], y_out = base_y + c[3:2], with plot high for exactly 16 consecutive cycles.
REQ-014 SHALL use colour 3'b011 for CLEAR, 3'b111 for a player DRAW, 3'b100 for a bird DRAW, and 3'b110 for a bird DRAW while fall = 1.
REQ-015 SHALL timing: if pass starts at cycle 0, plot is high in cycles 1-16 and doneDrawing rises in cycle 17.
REQ-016 SHALL hold doneDrawing high until STATE leaves the code that started the pass, then drop it the next cycle.
REQ-017 SHALL, if STATE leaves CLEAR or DRAW mid-pass, drop plot the next cycle, keep doneDrawing low, and discard the pass.
REQ-018 SHALL, on each cycle STATE is RIGHT, LEFT, DOWN or UP, step the PorB-selected x or y by 1, saturating at 0 and at 156 (x) or 116 (y).
REQ-019 SHALL decrement ammo (reset value 3) by 1 on each shoot pulse while ammo > 0, and ignore shoot while ammo = 0.
REQ-020 SHALL set isShot when shoot arrives with ammo > 0 and player centre (px+2, py+2) lies inside the bird box.
REQ-021 SHALL assert outOfAmmo while ammo = 0.
REQ-022 SHALL set escape when ammo reaches 0 with isShot = 0; if the last shot hits in the same cycle, isShot is set and escape stays 0.
REQ-023 SHALL set leave when (fall and bird y = 116) or (fly and bird y = 0).
REQ-024 SHALL, when STATE = IS_SHOT and leave = 1, on the next cycle clear isShot, escape and leave, reload ammo to 3, and respawn bird at (78,100).
REQ-025 SHALL have all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, on reset, immediately set player to (78,58), bird to (78,100), ammo to 3, and hits to 0.
REQ-027 SHALL, on reset, force doneDrawing, plot, isShot, escape, leave, outOfAmmo, x_out, y_out and colour to 0 and abort any pass.
REQ-028 SHALL, on reset released while STATE = CLEAR, start a fresh pass on the first clock edge.

Configuration
REQ-029 SHALL, with macro SPRITE_HIT_COUNT_EN defined, increment hits on each rising edge of isShot, wrapping 255 to 0, and leave it unchanged by respawn.
REQ-030 SHALL, without SPRITE_HIT_COUNT_EN, tie hits to 8'd0 and build no counter logic.

Verification
REQ-031 SHALL cover: reset, then STATE = CLEAR, PorB = 0 -> 16 plots, x 78..81, y 58..61, colour 011, doneDrawing rising at cycle 17.
REQ-032 SHALL cover: player x = 156, STATE = RIGHT for 3 cycles -> x stays 156; then LEFT for 1 cycle -> x = 155.
REQ-033 SHALL cover: DRAW pass aborted at cycle 5 by STATE = RIGHT -> plot low by cycle 6, doneDrawing never high.
REQ-034 SHALL cover: player (77,99), bird (78,100), shoot -> isShot = 1, ammo 2, escape 0, hits 1 (macro on) or 0 (macro off).
REQ-035 SHALL cover: three missing shoots -> outOfAmmo = 1, escape = 1; a fourth shoot is ignored.
REQ-036 SHALL cover: fall = 1, bird y stepped to 116, STATE = IS_SHOT -> leave = 1, then next cycle bird at (78,100), ammo 3, flags 0.
